// File: rtl/spi_mem_pkg.sv
// -----------------------------------------------------------------------------
// spi_mem_pkg
// Shared constants and types for the SPI mode-0 memory responder:
//   - opcode constants (READ, WRITE, RDSR)
//   - width of the serial address field
//   - FSM state enumeration (ST_STATUS exists only with SPI_MEM_RESP_STATUS_EN)
// -----------------------------------------------------------------------------
package spi_mem_pkg;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_RDSR  = 8'h05;

   // Serial address field length; only the low $clog2(DEPTH) bits are kept.
   localparam int ADDR_BITS = 24;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_READ,
      ST_WRITE,
      ST_IGNORE
`ifdef SPI_MEM_RESP_STATUS_EN
      , ST_STATUS
`endif
   } state_t;

endpackage

// File: rtl/spi_mem_responder_if.sv
// -----------------------------------------------------------------------------
// spi_mem_responder_if
// SPI pins plus the committed-write side channel of the memory responder.
//   sclk, cs_n, mosi : driven by the initiator (master modport)
//   miso             : serial read data from the responder
//   wr_valid/addr/data : one-clk notification per committed write byte
//   busy             : responder is inside a transaction
// Parameter DEPTH must match the responder's DEPTH (sets wr_addr width).
// -----------------------------------------------------------------------------
interface spi_mem_responder_if #(
   parameter int DEPTH = 256
);
   localparam int AW = $clog2(DEPTH);

   logic          sclk;
   logic          cs_n;
   logic          mosi;
   logic          miso;
   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          busy;

   modport master (
      output sclk, cs_n, mosi,
      input  miso, wr_valid, wr_addr, wr_data, busy
   );

   modport slave (
      input  sclk, cs_n, mosi,
      output miso, wr_valid, wr_addr, wr_data, busy
   );
endinterface

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchronizer followed by a one-flop edge detector.
//   clk, rst : system clock, async active-high reset
//   d        : asynchronous input pin
//   rise     : one-clk pulse on a synchronized 0->1 transition
//   fall     : one-clk pulse on a synchronized 1->0 transition
// All flops reset to 0, so a pin that is already low at reset release produces
// no edge; a pin that is high produces a single harmless rise.
// -----------------------------------------------------------------------------
module spi_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] chain;
   logic              prev;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour, regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
         prev <= chain[STAGES-1];
      end
   end

   assign rise = chain[STAGES-1] & ~prev;
   assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_mem_responder.sv
// -----------------------------------------------------------------------------
// spi_mem_responder
// SPI mode-0 memory target with a byte-addressed RAM. Serves READ (0x03) and
// WRITE (0x02) bursts with a 24-bit MSB-first address and auto-increment
// (wrapping modulo DEPTH). The SPI pins are oversampled on clk (>= 4x sclk).
//   clk, rst : system clock, async active-high reset
//   bus      : spi_mem_responder_if.slave (sclk/cs_n/mosi in, miso,
//              wr_valid/wr_addr/wr_data, busy out)
// Optional feature macro: SPI_MEM_RESP_STATUS_EN adds command 0x05 (RDSR),
// which streams an 8-bit count of committed write bytes.
// -----------------------------------------------------------------------------
module spi_mem_responder
   import spi_mem_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int SYNC_STAGES = 2
) (
   input logic                clk,
   input logic                rst,
   spi_mem_responder_if.slave bus
);
   localparam int AW   = $clog2(DEPTH);
   // Shift history wide enough for both the opcode and the kept address bits.
   localparam int SH_W = ((AW > 8) ? AW : 8) - 1;

   logic sclk_rise, sclk_fall, cs_rise, cs_fall;

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk(clk), .rst(rst), .d(bus.sclk), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
      .clk(clk), .rst(rst), .d(bus.cs_n), .rise(cs_rise), .fall(cs_fall)
   );

   // mosi needs no edge detection, only the same delay as the sclk path so the
   // sampled bit lines up with the detected rising edge.
   logic [SYNC_STAGES-1:0] mosi_chain;
   logic                   mosi_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mosi_chain <= '0;
      end else begin
         mosi_chain[0] <= bus.mosi;
         for (int i = 1; i < SYNC_STAGES; i++) mosi_chain[i] <= mosi_chain[i-1];
      end
   end
   assign mosi_s = mosi_chain[SYNC_STAGES-1];

   state_t          state_q, state_d;
   logic [4:0]      bit_cnt_q, bit_cnt_d;
   logic [2:0]      rd_cnt_q, rd_cnt_d;
   logic [SH_W-1:0] sh_q, sh_d;
   logic [AW-1:0]   addr_q, addr_d, addr_inc, addr_in, rd_addr;
   logic [7:0]      out_q, out_d, byte_in, ram_q, next_byte;
   logic            miso_q, miso_d, is_read_q, is_read_d;
   logic            wr_en, serving;
   logic            wr_valid_q;
   logic [AW-1:0]   wr_addr_q;
   logic [7:0]      wr_data_q;
   logic [7:0]      mem [DEPTH];

   assign byte_in  = {sh_q[6:0], mosi_s};
   assign addr_in  = {sh_q[AW-2:0], mosi_s};
   assign addr_inc = addr_q + 1'b1;
   // At the end of the address phase the first byte comes from the new address.
   assign rd_addr  = (state_q == ST_ADDR) ? addr_in : addr_inc;
   assign ram_q    = mem[rd_addr];

`ifdef SPI_MEM_RESP_STATUS_EN
   logic [7:0] wr_count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        wr_count_q <= '0;
      else if (wr_en) wr_count_q <= wr_count_q + 8'd1;
   end

   assign next_byte = (state_q == ST_STATUS) ? wr_count_q : ram_q;
   assign serving   = (state_q == ST_READ) || (state_q == ST_STATUS);
`else
   assign next_byte = ram_q;
   assign serving   = (state_q == ST_READ);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         rd_cnt_q   <= '0;
         sh_q       <= '0;
         addr_q     <= '0;
         out_q      <= '0;
         miso_q     <= 1'b0;
         is_read_q  <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         sh_q       <= sh_d;
         addr_q     <= addr_d;
         out_q      <= out_d;
         miso_q     <= miso_d;
         is_read_q  <= is_read_d;
         wr_valid_q <= wr_en;
         if (wr_en) begin
            wr_addr_q <= addr_q;
            wr_data_q <= byte_in;
         end
      end
   end

   // NOTE: the RAM has no reset branch; clearing a memory array needs a loop
   // over every word and prevents block-RAM inference.
   always_ff @(posedge clk) begin
      if (wr_en) mem[addr_q] <= byte_in;
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path through
      // the case statement can infer a latch.
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      sh_d      = sh_q;
      addr_d    = addr_q;
      out_d     = out_q;
      miso_d    = miso_q;
      is_read_d = is_read_q;
      wr_en     = 1'b0;

      if (cs_rise) begin
         // Deselect wins over any sclk edge seen in the same clk.
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
         rd_cnt_d  = '0;
         miso_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cs_fall) begin
                  state_d   = ST_CMD;
                  bit_cnt_d = '0;
               end
            end
            ST_CMD: begin
               if (sclk_rise) begin
                  sh_d      = {sh_q[SH_W-2:0], mosi_s};
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = '0;
                     case (byte_in)
                        CMD_READ:  begin state_d = ST_ADDR; is_read_d = 1'b1; end
                        CMD_WRITE: begin state_d = ST_ADDR; is_read_d = 1'b0; end
`ifdef SPI_MEM_RESP_STATUS_EN
                        CMD_RDSR: begin
                           state_d  = ST_STATUS;
                           out_d    = wr_count_q;
                           rd_cnt_d = '0;
                           miso_d   = 1'b0;
                        end
`endif
                        default:   state_d = ST_IGNORE;
                     endcase
                  end
               end
            end
            ST_ADDR: begin
               if (sclk_rise) begin
                  sh_d      = {sh_q[SH_W-2:0], mosi_s};
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'(ADDR_BITS - 1)) begin
                     bit_cnt_d = '0;
                     addr_d    = addr_in;
                     if (is_read_q) begin
                        state_d  = ST_READ;
                        out_d    = ram_q;
                        rd_cnt_d = '0;
                        miso_d   = 1'b0;
                     end else begin
                        state_d = ST_WRITE;
                     end
                  end
               end
            end
            ST_WRITE: begin
               if (sclk_rise) begin
                  sh_d      = {sh_q[SH_W-2:0], mosi_s};
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = '0;
                     wr_en     = 1'b1;
                     addr_d    = addr_inc;
                  end
               end
            end
            ST_IGNORE: ;
            default: begin
               // READ and status readout: shift on the falling edge, reload at
               // each byte boundary.
               if (serving && sclk_fall) begin
                  miso_d = out_q[7];
                  if (rd_cnt_q == 3'd7) begin
                     rd_cnt_d = '0;
                     out_d    = next_byte;
                     addr_d   = addr_inc;
                  end else begin
                     rd_cnt_d = rd_cnt_q + 3'd1;
                     out_d    = {out_q[6:0], 1'b0};
                  end
               end
            end
         endcase
      end
   end

   assign bus.miso     = serving & miso_q;
   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.wr_valid = wr_valid_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_mem_responder
// Directed bench for spi_mem_responder (DEPTH=256, SYNC_STAGES=2). Acts as the
// SPI initiator with sclk = clk/12 and records every wr_valid pulse.
// Honours SPI_MEM_RESP_STATUS_EN for the expected RDSR result.
// -----------------------------------------------------------------------------
module tb_spi_mem_responder;
   localparam int DEPTH = 256;
   localparam int AW    = $clog2(DEPTH);
   localparam int HALF  = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   logic [AW+7:0] wq [$];

   spi_mem_responder_if #(.DEPTH(DEPTH)) bus ();

   spi_mem_responder #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.wr_valid === 1'b1) wq.push_back({bus.wr_addr, bus.wr_data});

   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = '0;
      for (int i = 7; i > 7 - n; i--) begin
         bus.mosi = tx[i];
         repeat (HALF) @(negedge clk);
         rx[i] = bus.miso;
         bus.sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         bus.sclk = 1'b0;
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      spi_bits(tx, 8, rx);
   endtask

   task automatic cs_begin();
      wq.delete();
      bus.cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic cs_end();
      repeat (HALF) @(negedge clk);
      bus.cs_n = 1'b1;
      repeat (2 * HALF) @(negedge clk);
   endtask

   task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
      logic [7:0] rx;
      spi_byte(op, rx);
      spi_byte(a[23:16], rx);
      spi_byte(a[15:8], rx);
      spi_byte(a[7:0], rx);
   endtask

   task automatic write_bytes(input logic [23:0] a, input logic [7:0] d [3], input int n);
      logic [7:0] rx;
      cs_begin();
      send_hdr(8'h02, a);
      for (int i = 0; i < n; i++) spi_byte(d[i], rx);
      cs_end();
   endtask

   task automatic read2(input logic [23:0] a, output logic [7:0] d0, output logic [7:0] d1);
      cs_begin();
      send_hdr(8'h03, a);
      spi_byte(8'h00, d0);
      spi_byte(8'h00, d1);
      cs_end();
   endtask

   task automatic test_reset();
      n_vec++; if (bus.miso !== 1'b0) begin n_err++; $display("FAIL reset_miso got %b want 0", bus.miso); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      n_vec++; if (bus.wr_valid !== 1'b0) begin n_err++; $display("FAIL reset_wr_valid got %b want 0", bus.wr_valid); end
      n_vec++; if (bus.wr_addr !== '0) begin n_err++; $display("FAIL reset_wr_addr got %h want 00", bus.wr_addr); end
      n_vec++; if (bus.wr_data !== 8'h00) begin n_err++; $display("FAIL reset_wr_data got %h want 00", bus.wr_data); end
   endtask

   task automatic test_write();
      logic [7:0] rx;
      cs_begin();
      send_hdr(8'h02, 24'h000010);
      spi_byte(8'hAA, rx);
      spi_byte(8'hBB, rx);
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL write_busy got %b want 1", bus.busy); end
      cs_end();
      n_vec++; if (wq.size() != 2) begin n_err++; $display("FAIL write_count got %0d want 2", wq.size()); end
      n_vec++; if ((wq.size() > 0 ? wq[0] : 'x) !== 16'h10AA) begin n_err++; $display("FAIL write_pulse0 got %h want 10aa", (wq.size() > 0 ? wq[0] : 'x)); end
      n_vec++; if ((wq.size() > 1 ? wq[1] : 'x) !== 16'h11BB) begin n_err++; $display("FAIL write_pulse1 got %h want 11bb", (wq.size() > 1 ? wq[1] : 'x)); end
   endtask

   task automatic test_read();
      logic [7:0] d0, d1;
      read2(24'h000010, d0, d1);
      n_vec++; if (d0 !== 8'hAA) begin n_err++; $display("FAIL read_byte0 got %h want aa", d0); end
      n_vec++; if (d1 !== 8'hBB) begin n_err++; $display("FAIL read_byte1 got %h want bb", d1); end
   endtask

   task automatic test_wrap();
      logic [7:0] d [3];
      logic [7:0] d0, d1;
      d = '{8'h11, 8'h22, 8'h00};
      write_bytes(24'h0000FF, d, 2);
      n_vec++; if ((wq.size() > 0 ? wq[0] : 'x) !== 16'hFF11) begin n_err++; $display("FAIL wrap_pulse0 got %h want ff11", (wq.size() > 0 ? wq[0] : 'x)); end
      n_vec++; if ((wq.size() > 1 ? wq[1] : 'x) !== 16'h0022) begin n_err++; $display("FAIL wrap_pulse1 got %h want 0022", (wq.size() > 1 ? wq[1] : 'x)); end
      read2(24'h0000FF, d0, d1);
      n_vec++; if ({d0, d1} !== 16'h1122) begin n_err++; $display("FAIL wrap_read got %h want 1122", {d0, d1}); end
      // Upper address bits must be ignored.
      read2(24'h1234FF, d0, d1);
      n_vec++; if ({d0, d1} !== 16'h1122) begin n_err++; $display("FAIL wrap_upper_addr got %h want 1122", {d0, d1}); end
   endtask

   task automatic test_abort_write();
      logic [7:0] d [3];
      logic [7:0] rx, d0, d1;
      d = '{8'h5A, 8'h00, 8'h00};
      write_bytes(24'h000020, d, 1);
      cs_begin();
      send_hdr(8'h02, 24'h000020);
      spi_bits(8'hFF, 5, rx);
      cs_end();
      n_vec++; if (wq.size() != 0) begin n_err++; $display("FAIL abort_no_write got %0d want 0", wq.size()); end
      read2(24'h000020, d0, d1);
      n_vec++; if (d0 !== 8'h5A) begin n_err++; $display("FAIL abort_ram got %h want 5a", d0); end
   endtask

   task automatic test_unknown_cmd();
      logic [7:0] rx;
      logic [31:0] seen;
      cs_begin();
      spi_byte(8'h9F, rx);
      seen = '0;
      for (int i = 0; i < 4; i++) begin
         spi_byte(8'hFF, rx);
         seen = {seen[23:0], rx};
      end
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL ignore_busy got %b want 1", bus.busy); end
      cs_end();
      n_vec++; if (seen !== 32'h0) begin n_err++; $display("FAIL ignore_miso got %h want 00000000", seen); end
      n_vec++; if (wq.size() != 0) begin n_err++; $display("FAIL ignore_no_write got %0d want 0", wq.size()); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] rx, d0, d1;
      cs_begin();
      spi_byte(8'h03, rx);
      spi_byte(8'h00, rx);
      spi_bits(8'h00, 4, rx);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
      n_vec++; if (bus.miso !== 1'b0) begin n_err++; $display("FAIL rstmid_miso got %b want 0", bus.miso); end
      // Without a fresh cs_n fall, further clocks must not start a transaction.
      spi_byte(8'hFF, rx);
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_no_resume got %b want 0", bus.busy); end
      cs_end();
      read2(24'h000010, d0, d1);
      n_vec++; if (d0 !== 8'hAA) begin n_err++; $display("FAIL rstmid_read got %h want aa", d0); end
   endtask

   task automatic test_status();
      logic [7:0] d [3];
      logic [7:0] rx, s0, s1, exp_s;
`ifdef SPI_MEM_RESP_STATUS_EN
      exp_s = 8'h03;
`else
      exp_s = 8'h00;
`endif
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      d = '{8'h01, 8'h02, 8'h03};
      write_bytes(24'h000040, d, 3);
      n_vec++; if (wq.size() != 3) begin n_err++; $display("FAIL status_writes got %0d want 3", wq.size()); end
      cs_begin();
      spi_byte(8'h05, rx);
      spi_byte(8'h00, s0);
      spi_byte(8'h00, s1);
      cs_end();
      n_vec++; if (s0 !== exp_s) begin n_err++; $display("FAIL status_byte0 got %h want %h", s0, exp_s); end
      n_vec++; if (s1 !== exp_s) begin n_err++; $display("FAIL status_byte1 got %h want %h", s1, exp_s); end
   endtask

   initial begin
      bus.sclk = 1'b0;
      bus.cs_n = 1'b1;
      bus.mosi = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      test_reset();
      test_write();
      test_read();
      test_wrap();
      test_abort_write();
      test_unknown_cmd();
      test_reset_mid();
      test_status();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
